// File: rtl/burst_addr_gen_if.sv
// Command and bus-address bundle for burst_addr_gen.
//
// Both channels use the same valid/ready rule. A transfer happens on a
// rising clk edge where valid && ready are both 1. Once a producer raises
// valid, it holds valid and its payload stable until that transfer
// happens. Ready may toggle freely.
//
// Modport roles:
//   master - the address generator (accepts commands, drives bus beats)
//   slave  - its environment (issues commands, accepts bus beats)
interface burst_addr_gen_if #(
   parameter int BITWIDTH = 8,
   parameter int LENWIDTH = 4
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [BITWIDTH-1:0] cmd_addr;
   logic [LENWIDTH-1:0] cmd_len;
   logic                cmd_write;

   logic                bus_valid;
   logic                bus_ready;
   logic [BITWIDTH-1:0] bus_addr;
   logic                bus_write;
   logic                bus_last;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len, cmd_write, bus_ready,
      output cmd_ready, bus_valid, bus_addr, bus_write, bus_last
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, cmd_write, bus_ready,
      input  cmd_ready, bus_valid, bus_addr, bus_write, bus_last
   );
endinterface

// File: rtl/burst_addr_gen.sv
// Burst address generator: takes one command (start, beat count, direction)
// and issues one incrementing address beat per accepted bus cycle.
// The end of the burst is found by NBitComparator checking beat_cnt+1 < len.
// Optional feature macro: BURST_ERR_EN. When it is defined, err flags
// zero-length or wrapping bursts. When it is undefined, err is tied to 0.

// Less-than comparator. It takes the sign bit of a - b, so it is only exact
// when both operands have their MSB clear. The caller guarantees that.
module NBitComparator #(
   parameter int BITWIDTH = 8
) (
   input  logic [BITWIDTH-1:0] a,
   input  logic [BITWIDTH-1:0] b,
   output logic                lt
);
   logic [BITWIDTH-1:0] diff;

   assign diff = a - b;
   assign lt   = diff[BITWIDTH-1];
endmodule

module burst_addr_gen #(
   parameter int BITWIDTH = 8,
   parameter int LENWIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   burst_addr_gen_if.master bif,
   output logic             done,
   output logic             err,
   output logic             dbg_state_o
);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [BITWIDTH-1:0] addr_q, addr_d;
   logic [LENWIDTH-1:0] len_q, len_d;
   logic                write_q, write_d;
   logic [LENWIDTH-1:0] cnt_q, cnt_d;
   logic                done_q, done_d;

   logic                in_idle;
   logic                in_issue;
   logic                accept;
   logic                xfer;
   logic                lt;
   logic                last_w;
   logic [LENWIDTH-1:0] cnt_inc;

   assign in_idle  = (state_q == IDLE);
   assign in_issue = (state_q == ISSUE);
   assign accept   = in_idle && bif.cmd_valid;
   assign xfer     = in_issue && bif.bus_ready;

   // cnt_q never exceeds len-1 while issuing, so cnt_q+1 fits in LENWIDTH bits.
   assign cnt_inc = cnt_q + LENWIDTH'(1);

   // The extra zero MSB keeps the sign-bit compare exact for any length.
   NBitComparator #(.BITWIDTH(LENWIDTH + 1)) u_cmp (
      .a  ({1'b0, cnt_inc}),
      .b  ({1'b0, len_q}),
      .lt (lt)
   );

   assign last_w = ~lt;

   // Next-state and datapath updates for the IDLE/ISSUE control.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      write_d = write_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = bif.cmd_addr;
               len_d   = bif.cmd_len;
               write_d = bif.cmd_write;
               cnt_d   = '0;
               if (bif.cmd_len != '0) begin
                  state_d = ISSUE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (xfer) begin
               cnt_d = cnt_inc;
               if (last_w) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset abandons any burst without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // All outputs are forced low during reset, including cmd_ready.
   assign bif.cmd_ready = in_idle & ~reset;
   assign bif.bus_valid = in_issue & ~reset;
   assign bif.bus_addr  = (addr_q + BITWIDTH'(cnt_q)) & {BITWIDTH{bif.bus_valid}};
   assign bif.bus_write = write_q & bif.bus_valid;
   assign bif.bus_last  = last_w & bif.bus_valid;
   assign done          = done_q & ~reset;
   assign dbg_state_o   = state_q;

`ifdef BURST_ERR_EN
   logic                err_q;
   logic                err_calc;
   logic [BITWIDTH:0]   end_sum;

   // start + len > 2^BITWIDTH is the same as start + len - 1 > 2^BITWIDTH - 1.
   assign end_sum  = {1'b0, bif.cmd_addr} + {{(BITWIDTH + 1 - LENWIDTH){1'b0}}, bif.cmd_len};
   assign err_calc = (bif.cmd_len == '0) || (end_sum > {1'b1, {BITWIDTH{1'b0}}});

   // Sticky error, re-evaluated on each accepted command.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= err_calc;
      end
   end

   assign err = err_q & ~reset;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_addr_gen.sv
// Bench for burst_addr_gen: table of single bursts, hand-written corner
// sequences, and random traffic checked cycle-by-cycle against a
// transaction-queue model of the expected beats.
module tb_burst_addr_gen;

   localparam int BW = 8;
   localparam int LW = 4;
`ifdef BURST_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic done;
   logic err;
   logic dbg_state;

   burst_addr_gen_if #(.BITWIDTH(BW), .LENWIDTH(LW)) bif();

   burst_addr_gen #(.BITWIDTH(BW), .LENWIDTH(LW)) dut (
      .clk         (clk),
      .reset       (reset),
      .bif         (bif),
      .done        (done),
      .err         (err),
      .dbg_state_o (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of beat addresses still to be issued
   int m_beats[$];
   bit m_write;
   bit m_done;
   bit m_err;

   // Last sampled outputs and the log of transferred beats
   logic          s_valid, s_last, s_done, s_cmd_ready, s_err;
   logic [BW-1:0] s_addr;
   int            obs_q[$];
   logic          obs_last;

   typedef struct {
      int addr;
      int len;
      int write;
      int exp_first;
      int exp_last;
      int exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare against the model, advance one clock, then update the model.
   task automatic cycle();
      int e_addr;
      #1;
      if (reset) begin
         chk("rst_cmd_ready", 32'(bif.cmd_ready), 0);
         chk("rst_bus_valid", 32'(bif.bus_valid), 0);
         chk("rst_bus_addr", 32'(bif.bus_addr), 0);
         chk("rst_bus_write", 32'(bif.bus_write), 0);
         chk("rst_bus_last", 32'(bif.bus_last), 0);
         chk("rst_done", 32'(done), 0);
         chk("rst_err", 32'(err), 0);
      end else begin
         e_addr = (m_beats.size() > 0) ? m_beats[0] : 0;
         chk("cmd_ready", 32'(bif.cmd_ready), 32'(m_beats.size() == 0));
         chk("bus_valid", 32'(bif.bus_valid), 32'(m_beats.size() > 0));
         chk("bus_addr", 32'(bif.bus_addr), 32'(e_addr));
         chk("bus_write", 32'(bif.bus_write), 32'((m_beats.size() > 0) && m_write));
         chk("bus_last", 32'(bif.bus_last), 32'(m_beats.size() == 1));
         chk("done", 32'(done), 32'(m_done));
         chk("err", 32'(err), 32'(m_err));
      end
      s_valid     = bif.bus_valid;
      s_addr      = bif.bus_addr;
      s_last      = bif.bus_last;
      s_done      = done;
      s_cmd_ready = bif.cmd_ready;
      s_err       = err;
      if (s_valid && bif.bus_ready) begin
         obs_q.push_back(int'(s_addr));
         obs_last = s_last;
      end
      @(posedge clk);
      if (reset) begin
         m_beats.delete();
         m_done  = 1'b0;
         m_err   = 1'b0;
         m_write = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_beats.size() == 0) begin
            if (bif.cmd_valid) begin
               for (int i = 0; i < int'(bif.cmd_len); i++)
                  m_beats.push_back((int'(bif.cmd_addr) + i) % (1 << BW));
               m_write = bif.cmd_write;
               if (bif.cmd_len == 0) m_done = 1'b1;
               m_err = ERR_EN && ((bif.cmd_len == 0) ||
                                  (int'(bif.cmd_addr) + int'(bif.cmd_len) > (1 << BW)));
            end
         end else if (bif.bus_ready) begin
            void'(m_beats.pop_front());
            if (m_beats.size() == 0) m_done = 1'b1;
         end
      end
      #1;
   endtask

   task automatic send_cmd(input int addr, input int len, input int wr);
      bif.cmd_addr  = BW'(addr);
      bif.cmd_len   = LW'(len);
      bif.cmd_write = wr[0];
      bif.cmd_valid = 1'b1;
   endtask

   // Run cycles until done is seen; returns cycles taken, or the bound on timeout.
   task automatic wait_done(input int bound, output int k);
      k = 0;
      s_done = 1'b0;
      while (!s_done && k < bound) begin
         cycle();
         k++;
      end
   endtask

   initial begin
      int k;
      int hold;
      vecs[0] = '{addr: 'h10, len: 4,  write: 1, exp_first: 'h10, exp_last: 'h13, exp_err: 0};
      vecs[1] = '{addr: 'h40, len: 1,  write: 0, exp_first: 'h40, exp_last: 'h40, exp_err: 0};
      vecs[2] = '{addr: 'h00, len: 0,  write: 1, exp_first: 0,    exp_last: 0,    exp_err: 1};
      vecs[3] = '{addr: 'hFE, len: 4,  write: 0, exp_first: 'hFE, exp_last: 'h01, exp_err: 1};
      vecs[4] = '{addr: 'hF1, len: 15, write: 1, exp_first: 'hF1, exp_last: 'hFF, exp_err: 0};
      vecs[5] = '{addr: 'hFF, len: 1,  write: 1, exp_first: 'hFF, exp_last: 'hFF, exp_err: 0};

      reset = 1'b1;
      bif.cmd_valid = 1'b0;
      bif.cmd_addr  = '0;
      bif.cmd_len   = '0;
      bif.cmd_write = 1'b0;
      bif.bus_ready = 1'b1;
      m_write = 1'b0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      obs_last = 1'b0;
      repeat (2) cycle();
      reset = 1'b0;
      cycle();
      chk("idle_after_reset", 32'(s_cmd_ready), 1);

      // Table of single bursts with bus_ready held high
      for (int v = 0; v < 6; v++) begin
         send_cmd(vecs[v].addr, vecs[v].len, vecs[v].write);
         bif.bus_ready = 1'b1;
         cycle();
         chk("tbl_accept", 32'(s_cmd_ready), 1);
         bif.cmd_valid = 1'b0;
         obs_q.delete();
         wait_done(40, k);
         chk("tbl_done_latency", 32'(k), 32'(vecs[v].len + 1));
         chk("tbl_nbeats", 32'(obs_q.size()), 32'(vecs[v].len));
         if (obs_q.size() > 0) begin
            chk("tbl_first_addr", 32'(obs_q[0]), 32'(vecs[v].exp_first));
            chk("tbl_last_addr", 32'(obs_q[obs_q.size()-1]), 32'(vecs[v].exp_last));
            chk("tbl_last_flag", 32'(obs_last), 1);
         end
         chk("tbl_err", 32'(s_err), ERR_EN ? 32'(vecs[v].exp_err) : 0);
      end

      // Backpressure: second beat stalled for two cycles
      send_cmd('h40, 3, 1);
      cycle();
      bif.cmd_valid = 1'b0;
      obs_q.delete();
      cycle();
      hold = 0;
      bif.bus_ready = 1'b0;
      repeat (2) begin
         cycle();
         if (s_valid && s_addr == 8'h41) hold++;
      end
      bif.bus_ready = 1'b1;
      cycle();
      if (s_valid && s_addr == 8'h41) hold++;
      chk("bp_hold_cycles", 32'(hold), 3);
      cycle();
      chk("bp_third_addr", 32'(s_addr), 'h42);
      chk("bp_third_last", 32'(s_last), 1);
      cycle();
      chk("bp_done", 32'(s_done), 1);
      chk("bp_transfers", 32'(obs_q.size()), 3);

      // Reset in the middle of a burst
      send_cmd('h20, 8, 0);
      cycle();
      bif.cmd_valid = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
      chk("mid_rst_valid", 32'(s_valid), 0);
      chk("mid_rst_done", 32'(s_done), 0);
      chk("mid_rst_ready", 32'(s_cmd_ready), 1);
      send_cmd('h80, 2, 1);
      cycle();
      bif.cmd_valid = 1'b0;
      cycle();
      chk("mid_rst_new_addr", 32'(s_addr), 'h80);
      wait_done(10, k);
      chk("mid_rst_new_done", 32'(k), 2);

      // Maximum length, with a second command held during the burst
      send_cmd('h00, 15, 1);
      cycle();
      send_cmd('h30, 2, 0);
      obs_q.delete();
      wait_done(40, k);
      chk("max_done_latency", 32'(k), 16);
      chk("max_nbeats", 32'(obs_q.size()), 15);
      chk("max_last_flag", 32'(obs_last), 1);
      chk("b2b_ready_in_done", 32'(s_cmd_ready), 1);
      bif.cmd_valid = 1'b0;
      cycle();
      chk("b2b_second_valid", 32'(s_valid), 1);
      chk("b2b_second_addr", 32'(s_addr), 'h30);
      wait_done(10, k);
      chk("b2b_second_done", 32'(k), 2);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         reset         = ($urandom_range(0, 59) == 0);
         bif.cmd_valid = ($urandom_range(0, 2) == 0);
         bif.cmd_addr  = BW'($urandom_range(0, 255));
         bif.cmd_len   = LW'($urandom_range(0, 15));
         bif.cmd_write = 1'($urandom_range(0, 1));
         bif.bus_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      reset = 1'b0;
      bif.cmd_valid = 1'b0;
      bif.bus_ready = 1'b1;
      repeat (20) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/burst_addr_gen.md
# burst_addr_gen

Burst address generator feeding the unidirectional bus: accepts a burst command (start address, beat count, direction) through a valid/ready handshake and issues one address beat per accepted bus cycle. Burst termination is decided by an internal `NBitComparator` instance, which checks whether the next beat index is still below the programmed length. The block sits directly upstream of the bus slave/memory model and is the sole driver of the bus address phase.

## Interface
- `BITWIDTH`, 8, address width.
- `LENWIDTH`, 4, width of the beat-count field; maximum burst length is 2^LENWIDTH-1 beats.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_addr` input BITWIDTH: start address.
- `cmd_len` input LENWIDTH: number of beats; 0 is legal and produces no beats.
- `cmd_write` input 1: direction (1 = write).
- `bus_valid` output 1: address beat valid.
- `bus_ready` input 1: slave accepts the beat.
- `bus_addr` output BITWIDTH: beat address.
- `bus_write` output 1: direction of the current burst.
- `bus_last` output 1: current beat is the final beat.
- `done` output 1: one-cycle pulse when a burst completes.
- `err` output 1: error flag; see Configuration.

## Operation
- States: IDLE and ISSUE.
- **IDLE**
  - `cmd_ready` = 1 whenever `reset` = 0.
  - On `cmd_valid && cmd_ready`, the block latches `cmd_addr`, `cmd_len` and `cmd_write`, and clears `beat_cnt` (LENWIDTH bits).
  - If `cmd_len` != 0, the next state is ISSUE.
  - If `cmd_len` == 0, the block stays in IDLE and pulses `done` in the next cycle.
- **ISSUE**
  - `bus_valid` = 1 and `cmd_ready` = 0.
  - `bus_addr` = start address + `beat_cnt`, modulo 2^BITWIDTH.
  - A beat transfers on `bus_valid && bus_ready`.
  - On transfer, `beat_cnt` increments. If `bus_last` = 1, the next state is IDLE and `done` pulses in the following cycle.
- **Comparator use**
  - `NBitComparator` is instantiated with `BITWIDTH = LENWIDTH+1`.
  - `a = {1'b0, beat_cnt+1}` and `b = {1'b0, len}`. The extra zero bit keeps the sign-bit result overflow-free.
  - `bus_last` = `~lt`, where `lt` is the comparator output, gated with `bus_valid`.
- **Stability:** while `bus_valid && !bus_ready`, `bus_addr`, `bus_write` and `bus_last` hold stable.
- **Command handling:** `cmd_*` inputs are ignored outside IDLE. Commands are never queued.

## Timing
- **Reset:** all outputs are 0 while `reset` = 1 (including `cmd_ready`). The first cycle after deassertion is IDLE with `cmd_ready` = 1.
- **Start latency:** command accepted in cycle N; first beat presented (`bus_valid` = 1) in cycle N+1.
- **Throughput:** one beat per cycle while `bus_ready` = 1. A burst of L beats with no stalls occupies cycles N+1 to N+L.
- **Completion:** `done` = 1 and `cmd_ready` = 1 in cycle N+L+1. The earliest next command is accepted in cycle N+L+1, so there is one bubble between bursts.
- **Zero length:** command accepted in cycle N; `done` in cycle N+1; `bus_valid` never asserts.
- **Reset mid-burst:** the burst is abandoned with no `done` pulse. The next cycle shows IDLE reset values.
- **Single-beat burst** (`cmd_len` = 1): `bus_last` = 1 on the first beat.
- **Maximum length** (`cmd_len` = 2^LENWIDTH-1): `beat_cnt+1` reaches 2^LENWIDTH-1 without overflow. It is computed in LENWIDTH+1 bits.

## Configuration
- Macro: `BURST_ERR_EN`.
- **Defined:**
  - `err` is set in the cycle after command acceptance if `cmd_len` == 0, or if start address + `cmd_len` - 1 exceeds 2^BITWIDTH-1 (the burst would wrap).
  - `err` is sticky until the next command is accepted or `reset` is asserted.
  - The burst still executes, with the address wrapping.
- **Undefined:** `err` is tied to 0 and no overflow logic is built. Address wrap is silent.

## Test plan
- **Nominal burst:** reset, then cmd addr=0x10, len=4, write=1, `bus_ready` held 1.
  - Beats 0x10, 0x11, 0x12, 0x13 in 4 consecutive cycles.
  - `bus_last` only on 0x13.
  - `done` one cycle later.
- **Backpressure:** len=3 from 0x40, `bus_ready` low for 2 cycles on the second beat.
  - 0x41 is held stable for 3 cycles.
  - Exactly 3 transfers total; `done` after 0x42.
- **Zero length:** len=0.
  - No `bus_valid`.
  - `done` in the cycle after acceptance.
  - `err` = 1 with `BURST_ERR_EN`, 0 without.
- **Wrap:** addr=0xFE, len=4 (BITWIDTH=8).
  - Beats 0xFE, 0xFF, 0x00, 0x01.
  - `err` = 1 only with `BURST_ERR_EN`.
- **Reset mid-burst:** len=8, assert `reset` after 3 beats.
  - Next cycle: `bus_valid` = 0, no `done`, `cmd_ready` = 1 after release.
  - A new cmd starts from its own address.
- **Max length and back-to-back:** len=15 (LENWIDTH=4), then a second command presented continuously.
  - 15 beats, `bus_last` on the 15th.
  - Second command accepted in the `done` cycle.
  - Commands presented during ISSUE are ignored.
